// File: rtl/fpu_fpd_to_int.sv
// Double-precision to signed 64-bit integer converter, truncating toward zero.
// The mantissa is aligned by a 32/16/8/4/2/1 right shifter, one stage per cycle.
module fpu_fpd_to_int (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] srca,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] dst,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIX   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic        sign_r;
  logic [63:0] mant_r;
  logic [5:0]  shAmt_r;
  logic [2:0]  cnt_r;
  logic        sticky_r;
  logic        ovf_r;
  logic        unf_r;
  logic        nan_r;
  logic        unfInexact_r;

  logic [10:0] srcExp_s;
  logic [51:0] srcFrac_s;
  logic [5:0]  srcShAmt_s;
  logic        srcOvf_s;
  logic        srcUnf_s;
  logic        srcNan_s;
  logic        stageEn_s;
  logic [63:0] stageMant_s;
  logic [63:0] lostBits_s;
  logic [63:0] fixDst_s;
  logic        fixInvalid_s;
  logic        fixInexact_s;

  // Input field decode and classification, used only on the accept edge.
  always_comb begin
    srcExp_s   = srca[62:52];
    srcFrac_s  = srca[51:0];
    // (1086 - e) mod 64 equals (62 - e[5:0]) mod 64 since 1086 = 1024 + 62.
    srcShAmt_s = 6'd62 - srcExp_s[5:0];
    srcNan_s   = (srcExp_s == 11'd2047) && (srcFrac_s != 52'd0);
    srcUnf_s   = (srcExp_s < 11'd1023);
    srcOvf_s   = (srcExp_s >= 11'd1086) &&
                 !(srca[63] && (srcExp_s == 11'd1086) && (srcFrac_s == 52'd0));
  end

  // One shifter stage: pick width by cnt, enable by the matching shift bit.
  always_comb begin
    stageEn_s   = 1'b0;
    stageMant_s = mant_r;
    lostBits_s  = 64'd0;
    case (cnt_r)
      3'd0: begin
        stageEn_s   = shAmt_r[5];
        stageMant_s = mant_r >> 6'd32;
        lostBits_s  = mant_r & 64'h0000_0000_FFFF_FFFF;
      end
      3'd1: begin
        stageEn_s   = shAmt_r[4];
        stageMant_s = mant_r >> 6'd16;
        lostBits_s  = mant_r & 64'h0000_0000_0000_FFFF;
      end
      3'd2: begin
        stageEn_s   = shAmt_r[3];
        stageMant_s = mant_r >> 6'd8;
        lostBits_s  = mant_r & 64'h0000_0000_0000_00FF;
      end
      3'd3: begin
        stageEn_s   = shAmt_r[2];
        stageMant_s = mant_r >> 6'd4;
        lostBits_s  = mant_r & 64'h0000_0000_0000_000F;
      end
      3'd4: begin
        stageEn_s   = shAmt_r[1];
        stageMant_s = mant_r >> 6'd2;
        lostBits_s  = mant_r & 64'h0000_0000_0000_0003;
      end
      3'd5: begin
        stageEn_s   = shAmt_r[0];
        stageMant_s = mant_r >> 6'd1;
        lostBits_s  = mant_r & 64'h0000_0000_0000_0001;
      end
      default: begin
        stageEn_s   = 1'b0;
        stageMant_s = mant_r;
        lostBits_s  = 64'd0;
      end
    endcase
  end

  // Final result selection by class priority: NaN, overflow, underflow, in range.
  always_comb begin
    fixDst_s     = 64'd0;
    fixInvalid_s = 1'b0;
    fixInexact_s = 1'b0;
    if (nan_r) begin
      fixDst_s     = 64'h8000_0000_0000_0000;
      fixInvalid_s = 1'b1;
    end else if (ovf_r) begin
      fixDst_s     = sign_r ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
      fixInvalid_s = 1'b1;
    end else if (unf_r) begin
      fixInexact_s = unfInexact_r;
    end else begin
      fixDst_s     = sign_r ? (~mant_r + 64'd1) : mant_r;
      fixInexact_s = sticky_r;
    end
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      dst          <= 64'd0;
      invalid      <= 1'b0;
      inexact      <= 1'b0;
      sign_r       <= 1'b0;
      mant_r       <= 64'd0;
      shAmt_r      <= 6'd0;
      cnt_r        <= 3'd0;
      sticky_r     <= 1'b0;
      ovf_r        <= 1'b0;
      unf_r        <= 1'b0;
      nan_r        <= 1'b0;
      unfInexact_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign_r       <= srca[63];
            mant_r       <= {1'b1, srcFrac_s, 11'd0};
            shAmt_r      <= srcShAmt_s;
            ovf_r        <= srcOvf_s;
            unf_r        <= srcUnf_s;
            nan_r        <= srcNan_s;
            unfInexact_r <= (srcExp_s != 11'd0) || (srcFrac_s != 52'd0);
            sticky_r     <= 1'b0;
            cnt_r        <= 3'd0;
            in_ready     <= 1'b0;
            state_r      <= SHIFT;
          end
        end
        SHIFT: begin
          if (stageEn_s) begin
            mant_r   <= stageMant_s;
            sticky_r <= sticky_r | (|lostBits_s);
          end
          if (cnt_r == 3'd5) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        FIX: begin
          dst       <= fixDst_s;
          invalid   <= fixInvalid_s;
          inexact   <= fixInexact_s;
          out_valid <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_fpd_to_int.sv
// Directed-vector bench for fpu_fpd_to_int with hand-computed results,
// covering latency, special operands, backpressure and mid-operation reset.
module tb_fpu_fpd_to_int;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] srca;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] dst;
  logic        invalid;
  logic        inexact;

  int checks;
  int failures;

  fpu_fpd_to_int dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .srca     (srca),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dst      (dst),
    .invalid  (invalid),
    .inexact  (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one operand and wait (bounded) for out_valid; returns edges counted.
  task automatic startAndWait(input logic [63:0] a, output int lat);
    @(negedge clk);
    srca     = a;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic runConv(input string tag, input logic [63:0] a, input logic [63:0] expDst,
                         input logic expInv, input logic expInx);
    int lat;
    @(negedge clk);
    checkEq({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    startAndWait(a, lat);
    checkEq({tag, ".latency"}, lat, 64'd7);
    checkEq({tag, ".dst"}, dst, expDst);
    checkEq({tag, ".invalid"}, {63'd0, invalid}, {63'd0, expInv});
    checkEq({tag, ".inexact"}, {63'd0, inexact}, {63'd0, expInx});
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkEq({tag, ".out_valid_drop"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    int lat;
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    srca      = 64'd0;
    repeat (3) @(negedge clk);
    checkEq("rst.in_ready", {63'd0, in_ready}, 64'd1);
    checkEq("rst.out_valid", {63'd0, out_valid}, 64'd0);
    checkEq("rst.dst", dst, 64'd0);
    checkEq("rst.flags", {62'd0, invalid, inexact}, 64'd0);
    reset_n = 1'b1;

    runConv("one",      64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    runConv("m2p5",     64'hC004_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    runConv("p2e63",    64'h43E0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    runConv("m2e63",    64'hC3E0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
    runConv("m2e63p",   64'hC3E0_0000_0000_0001, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    runConv("nan",      64'h7FF8_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    runConv("pinf",     64'h7FF0_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    runConv("minf",     64'hFFF0_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    runConv("half",     64'h3FE0_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b1);
    runConv("zero",     64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0);
    runConv("negzero",  64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b0);
    runConv("denorm",   64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000, 1'b0, 1'b1);
    runConv("p123",     64'h405E_C000_0000_0000, 64'h0000_0000_0000_007B, 1'b0, 1'b0);
    runConv("m1p5",     64'hBFF8_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    runConv("maxfin",   64'h43DF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FC00, 1'b0, 1'b0);

    // Backpressure: hold the 1.0 result while pulsing a foreign operand.
    startAndWait(64'h3FF0_0000_0000_0000, lat);
    checkEq("bp.latency", lat, 64'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkEq("bp.out_valid", {63'd0, out_valid}, 64'd1);
      checkEq("bp.in_ready", {63'd0, in_ready}, 64'd0);
      checkEq("bp.dst", dst, 64'd1);
      checkEq("bp.flags", {62'd0, invalid, inexact}, 64'd0);
      srca     = 64'h7FF8_0000_0000_0000;
      in_valid = (i % 2 == 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkEq("bp.release", {62'd0, out_valid, in_ready}, 64'd1);
    runConv("bp.next",  64'h4000_0000_0000_0000, 64'h0000_0000_0000_0002, 1'b0, 1'b0);

    // Reset during SHIFT abandons the conversion.
    startAndWait(64'h4008_0000_0000_0000, lat);
    checkEq("pre_rst.dst", dst, 64'd3);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    srca      = 64'h4014_0000_0000_0000;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkEq("mid_rst.out_valid", {63'd0, out_valid}, 64'd0);
    checkEq("mid_rst.in_ready", {63'd0, in_ready}, 64'd1);
    checkEq("mid_rst.dst", dst, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    checkEq("mid_rst.no_output", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    runConv("post_rst", 64'h3FF0_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_fpd_to_int.md
Name: fpu_fpd_to_int

Overview:
- Multi-cycle converter from IEEE-754 double (the format produced by the FPU double add/sub path) to a 64-bit signed integer.
- Rounding is truncation toward zero.
- It is the reverse of the FPU's normalise-into-double direction. Mantissa alignment uses an iterative 32/16/8/4/2/1 right shifter, one stage per cycle.
- Sits beside the double adder in the FPU. Uses a valid/ready handshake on both sides.

Parameters:
- None. All widths are fixed: 64-bit double in, 64-bit integer out.

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  srca is valid
- in_ready  out  1  block can accept an input (high only in IDLE)
- srca  in  64  IEEE-754 double: sign [63], exponent [62:52], fraction [51:0]
- out_valid  out  1  dst and flags are valid
- out_ready  in  1  consumer takes the result
- dst  out  64  two's-complement integer result
- invalid  out  1  NaN, infinity, or out-of-range input
- inexact  out  1  nonzero fraction bits were discarded

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, in_ready=1, out_valid=0, dst=0, invalid=0, inexact=0, internal registers cleared.
  - Reset mid-operation abandons the conversion. No output is produced.
- States: IDLE, SHIFT, FIX, DONE.
- IDLE:
  - On an edge with in_valid&in_ready, capture the fields: sign, e=srca[62:52], frac.
  - Build m={1'b1,frac,11'b0} (64 bits). Shift amount s=(1086-e)[5:0].
  - Classify the input:
    - ovf: e>=1086, excluding the single exact case sign=1, e=1086, frac=0.
    - unf: e<1023.
    - nan: e=2047 and frac!=0.
  - Clear sticky. Go to SHIFT with cnt=0.
- SHIFT, 6 cycles, cnt=0..5:
  - Stage width is 32>>cnt.
  - If s[5-cnt]=1: m=m>>width, and sticky|=OR of the bits shifted out.
  - At cnt=5 go to FIX.
- FIX, 1 cycle. Results by priority:
  - nan: dst=64'h8000_0000_0000_0000, invalid=1, inexact=0.
  - ovf (includes infinity): dst=7FFF_FFFF_FFFF_FFFF if sign=0, else 8000_0000_0000_0000; invalid=1, inexact=0.
  - unf: dst=0, invalid=0, inexact=1 if e!=0 or frac!=0, else 0. Denormals give 0 with inexact=1.
  - otherwise: dst = sign ? -m : m; invalid=0, inexact=sticky.
  - Go to DONE with out_valid=1.
- DONE:
  - dst and flags are held stable while out_valid=1 and out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. in_ready returns high the next cycle.
- Timing and throughput:
  - Fixed latency: out_valid rises 7 edges after the accept edge, regardless of operand class.
  - Minimum spacing between accepts is 9 cycles.
  - in_ready=0 outside IDLE. in_valid is ignored in SHIFT, FIX and DONE.
- Sign of zero: -0.0 gives 0, not negated garbage; two's complement of 0 is 0.
- Outputs and flags are registered. No combinational path from srca to dst.

Test Plan:
- srca=3FF0_0000_0000_0000 (1.0) -> dst=1, invalid=0, inexact=0; out_valid high exactly 7 cycles after accept.
- srca=C004_0000_0000_0000 (-2.5) -> dst=FFFF_FFFF_FFFF_FFFE, inexact=1, invalid=0.
- srca=43E0_0000_0000_0000 (2^63) -> dst=7FFF_FFFF_FFFF_FFFF, invalid=1. srca=C3E0_0000_0000_0000 (-2^63) -> dst=8000_0000_0000_0000, invalid=0, inexact=0.
- srca=7FF8_0000_0000_0000 (NaN) -> dst=8000_0000_0000_0000, invalid=1. srca=3FE0_0000_0000_0000 (0.5) -> dst=0, inexact=1. srca=0 -> dst=0, both flags 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> dst/flags stable, in_ready=0. Pulse in_valid during that time -> no capture. Raise out_ready -> IDLE, next input accepted.
- Drop reset_n during SHIFT -> immediate out_valid=0, in_ready=1, dst=0. After release, a new 1.0 conversion returns 1 with normal latency.
